light_ctrl: RTL and testbench
=============================

# light_ctrl

Lighting scheduler for the range-hood controller. It sits between the user-facing request sources (manual light switch, hood motor running, alarm/reminder) and the lighting LED. It decides which request owns the light, holds the light on for a programmable delay after the hood stops, and blinks the light while an alarm is active. It supersedes direct switch-to-LED wiring as the single owner of `light_led`.

## Interface
Parameters:
- `TICK_CYCLES`, 100_000_000: clk cycles per 1 s tick (reduce in simulation).
- `HOLD_S`, 10: seconds the light stays on after the hood stops; 0 disables hold. Must be ≤ 255.
- `BLINK_CYCLES`, 50_000_000: clk cycles per blink half-period.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-low reset; clock `clk`.
- `power_on`  in  1  system power state; 0 forces the light off.
- `manual_sw`  in  1  manual light request (level, already debounced).
- `hood_run`  in  1  hood motor running (level).
- `alarm`  in  1  alarm/clean-reminder active (level).
- `light_led`  out  1  lighting LED drive (registered).
- `light_state`  out  2  current state: 0 OFF, 1 ON, 2 HOLD, 3 BLINK.
- `hold_left`  out  8  whole seconds remaining in HOLD; 0 outside HOLD.

## Operation
- Reset (`rst`=0 at a posedge): state OFF, `light_led`=0, `hold_left`=0, tick and blink counters 0, `hood_run_d`=0.
- `hood_run_d` registers `hood_run` every cycle. A hood stop is `hood_run_d`=1 and `hood_run`=0.
- The priority is evaluated every cycle, highest first:
  1. `power_on`=0 → OFF from any state.
  2. `alarm`=1 → BLINK from any state.
  3. The per-state rules below.
- OFF: `manual_sw` or `hood_run` → ON. Otherwise stay.
- ON: light on. When `manual_sw`=0 and `hood_run`=0:
  - → HOLD if a hood stop occurs this cycle and `HOLD_S`>0. `hold_left` loads `HOLD_S` and the tick counter clears.
  - → OFF in all other cases, including a manual-only release and `HOLD_S`=0.
  - A simultaneous drop of both `manual_sw` and `hood_run` counts as a hood stop and goes to HOLD.
- HOLD: light on.
  - `manual_sw` or `hood_run` → ON; `hold_left` clears.
  - Otherwise the tick counter counts 0..`TICK_CYCLES`-1. On wrap, `hold_left` decrements.
  - When `hold_left` would go from 1 to 0 → OFF.
- BLINK: the blink counter clears on entry and `light_led`=1 for the first half-period. `light_led` toggles every `BLINK_CYCLES` cycles.
  - When `alarm` falls: → ON if `manual_sw` or `hood_run` is high, else OFF. HOLD is never entered from BLINK.
  - `hold_left` clears on entry.
- Outside HOLD the tick counter is held at 0. Outside BLINK the blink counter is held at 0.

## Timing
- All outputs are registered. An input sampled at edge N is reflected in `light_state`, `light_led` and `hold_left` immediately after edge N (1-cycle latency from input change to output change).
- `light_led` is 1 in ON and HOLD, 0 in OFF, and the blink phase in BLINK.
- The HOLD duration from the entry edge to the OFF edge is exactly `HOLD_S`×`TICK_CYCLES` cycles.
- A blink half-period is exactly `BLINK_CYCLES` cycles. The first toggle happens `BLINK_CYCLES` edges after entry.
- Reset mid-HOLD or mid-BLINK returns to OFF on that edge with all counters cleared.
- `power_on` falling and `alarm` rising on the same edge → OFF.

## Test plan
All scenarios use `TICK_CYCLES`=10, `HOLD_S`=3, `BLINK_CYCLES`=4.
- Reset and manual: with `rst`=0, the outputs are 0/0/0. Set `manual_sw`=1 with `power_on`=1 → `light_state`=1 and `light_led`=1 one cycle later. Set `manual_sw`=0 → OFF the next cycle, no HOLD.
- Hood hold: `hood_run` 1→0 → HOLD with `hold_left`=3. `hold_left` reads 2 after 10 cycles and 1 after 20. The state goes OFF and `light_led`=0 exactly 30 cycles after HOLD entry.
- Re-request in HOLD: raise `hood_run` at `hold_left`=2 → ON the next cycle with `hold_left`=0. Drop `hood_run` again → HOLD reloads to 3.
- Blink: raise `alarm` during ON → `light_led` pattern 1,1,1,1,0,0,0,0,1… Drop `alarm` with `manual_sw`=1 → ON. Drop it with no requests → OFF, never HOLD.
- Power override: drop `power_on` in HOLD with `hold_left`=2 → OFF next cycle. Drop `power_on` and raise `alarm` together → OFF.
- Reset mid-BLINK: assert `rst`=0 → OFF, `light_led`=0, `hold_left`=0 on that edge. After release with `alarm` still 1 → BLINK restarts with the LED on for 4 cycles.

Source files
------------

// File: rtl/light_ctrl.sv
// Range-hood lighting scheduler: arbitrates power, alarm, manual and hood requests
// onto the LED, with a post-hood hold timer and an alarm blink.
//
// state | meaning
// ------+-------------------------------------------------------------
// OFF   | light off, waiting for a manual or hood request
// ON    | light on while manual_sw or hood_run is held
// HOLD  | light on after a hood stop, counting hold_left down to 0
// BLINK | alarm active, LED toggles every BLINK_CYCLES cycles
module light_ctrl #(
    parameter int unsigned TICK_CYCLES  = 100_000_000,
    parameter int unsigned HOLD_S       = 10,
    parameter int unsigned BLINK_CYCLES = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       power_on,
    input  logic       manual_sw,
    input  logic       hood_run,
    input  logic       alarm,
    output logic       light_led,
    output logic [1:0] light_state,
    output logic [7:0] hold_left
);

    localparam int unsigned TICK_W  = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int unsigned BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

    localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICK_CYCLES - 1);
    localparam logic [TICK_W-1:0]  TICK_ONE   = TICK_W'(1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);
    localparam logic [BLINK_W-1:0] BLINK_ONE  = BLINK_W'(1);
    localparam logic [7:0]         HOLD_LOAD  = 8'(HOLD_S);
    localparam bit                 HOLD_EN    = (HOLD_S != 0);

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_ON    = 2'd1,
        ST_HOLD  = 2'd2,
        ST_BLINK = 2'd3
    } state_t;

    state_t             state, state_nxt;
    logic               led, led_nxt;
    logic [7:0]         hold_cnt, hold_nxt;
    logic [TICK_W-1:0]  tick_cnt, tick_nxt;
    logic [BLINK_W-1:0] blink_cnt, blink_nxt;
    logic               hood_run_d;
    logic               request;
    logic               hood_stop;

    assign request   = manual_sw | hood_run;
    assign hood_stop = hood_run_d & ~hood_run;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_OFF;
            led        <= 1'b0;
            hold_cnt   <= 8'd0;
            tick_cnt   <= '0;
            blink_cnt  <= '0;
            hood_run_d <= 1'b0;
        end else begin
            state      <= state_nxt;
            led        <= led_nxt;
            hold_cnt   <= hold_nxt;
            tick_cnt   <= tick_nxt;
            blink_cnt  <= blink_nxt;
            hood_run_d <= hood_run;
        end
    end

    always_comb begin
        state_nxt = state;
        led_nxt   = led;
        hold_nxt  = hold_cnt;
        tick_nxt  = '0;
        blink_nxt = '0;

        if (!power_on) begin
            state_nxt = ST_OFF;
        end else if (alarm) begin
            state_nxt = ST_BLINK;
            if (state != ST_BLINK) begin
                led_nxt = 1'b1;
            end else if (blink_cnt == BLINK_LAST) begin
                led_nxt = ~led;
            end else begin
                blink_nxt = blink_cnt + BLINK_ONE;
            end
        end else begin
            case (state)
                ST_OFF: begin
                    if (request) state_nxt = ST_ON;
                end
                ST_ON: begin
                    // only a hood stop earns the hold; a manual release goes dark
                    if (!request) begin
                        if (hood_stop && HOLD_EN) begin
                            state_nxt = ST_HOLD;
                            hold_nxt  = HOLD_LOAD;
                        end else begin
                            state_nxt = ST_OFF;
                        end
                    end
                end
                ST_HOLD: begin
                    if (request) begin
                        state_nxt = ST_ON;
                    end else if (tick_cnt == TICK_LAST) begin
                        if (hold_cnt <= 8'd1) state_nxt = ST_OFF;
                        else                  hold_nxt  = hold_cnt - 8'd1;
                    end else begin
                        tick_nxt = tick_cnt + TICK_ONE;
                    end
                end
                ST_BLINK: begin
                    state_nxt = request ? ST_ON : ST_OFF;
                end
                default: state_nxt = ST_OFF;
            endcase
        end

        // hold_left and the steady LED level follow directly from the next state
        if (state_nxt != ST_HOLD)  hold_nxt = 8'd0;
        if (state_nxt != ST_BLINK) led_nxt  = (state_nxt != ST_OFF);
    end

    assign light_state = state;
    assign light_led   = led;
    assign hold_left   = hold_cnt;

endmodule

// File: tb/tb_light_ctrl.sv
// Scoreboard bench for light_ctrl: directed scenarios plus random input segments,
// checked against a deadline/elapsed-time model of the lighting rules.
module tb_light_ctrl;

    localparam int TICK_C  = 10;
    localparam int HOLD_C  = 3;
    localparam int BLINK_C = 4;

    localparam int M_OFF = 0, M_ON = 1, M_HOLD = 2, M_BLINK = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       power_on = 1'b0;
    logic       manual_sw = 1'b0;
    logic       hood_run = 1'b0;
    logic       alarm = 1'b0;
    logic       light_led;
    logic [1:0] light_state;
    logic [7:0] hold_left;

    typedef struct {
        int         cyc;
        logic [1:0] st;
        logic       led;
        logic [7:0] hl;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    int now         = 0;
    int m_st        = M_OFF;
    bit m_hood_prev = 0;
    int deadline    = 0;
    int blink_start = 0;

    light_ctrl #(
        .TICK_CYCLES (TICK_C),
        .HOLD_S      (HOLD_C),
        .BLINK_CYCLES(BLINK_C)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .power_on   (power_on),
        .manual_sw  (manual_sw),
        .hood_run   (hood_run),
        .alarm      (alarm),
        .light_led  (light_led),
        .light_state(light_state),
        .hold_left  (hold_left)
    );

    always #5 clk = ~clk;

    // Advance the model by one clock edge using the inputs the DUT just sampled.
    task automatic model_step();
        bit   req;
        bit   stop;
        exp_t e;
        now++;
        if (!rst) begin
            m_st        = M_OFF;
            m_hood_prev = 0;
        end else begin
            req  = manual_sw || hood_run;
            stop = m_hood_prev && !hood_run;
            if (!power_on) begin
                m_st = M_OFF;
            end else if (alarm) begin
                if (m_st != M_BLINK) blink_start = now;
                m_st = M_BLINK;
            end else begin
                case (m_st)
                    M_OFF:   if (req) m_st = M_ON;
                    M_ON: begin
                        if (!req) begin
                            if (stop && HOLD_C > 0) begin
                                m_st     = M_HOLD;
                                deadline = now + HOLD_C * TICK_C;
                            end else begin
                                m_st = M_OFF;
                            end
                        end
                    end
                    M_HOLD: begin
                        if (req)                 m_st = M_ON;
                        else if (now >= deadline) m_st = M_OFF;
                    end
                    default: m_st = req ? M_ON : M_OFF;
                endcase
            end
            m_hood_prev = hood_run;
        end

        e.cyc = now;
        e.st  = 2'(m_st);
        case (m_st)
            M_OFF:   e.led = 1'b0;
            M_BLINK: e.led = (((now - blink_start) / BLINK_C) % 2) == 0;
            default: e.led = 1'b1;
        endcase
        e.hl = (m_st == M_HOLD) ? 8'((deadline - now + TICK_C - 1) / TICK_C) : 8'd0;
        exp_q.push_back(e);
    endtask

    task automatic cycle(input logic r, input logic p, input logic m, input logic h,
                         input logic a, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            rst       = r;
            power_on  = p;
            manual_sw = m;
            hood_run  = h;
            alarm     = a;
            @(posedge clk);
            model_step();
        end
    endtask

    // monitor: outputs are valid every cycle once the scoreboard has an entry
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (light_state !== e.st) begin
                n_fail++;
                $display("FAIL light_state cyc=%0d got=%0d want=%0d", e.cyc, light_state, e.st);
            end
            n_checks++;
            if (light_led !== e.led) begin
                n_fail++;
                $display("FAIL light_led cyc=%0d got=%0b want=%0b", e.cyc, light_led, e.led);
            end
            n_checks++;
            if (hold_left !== e.hl) begin
                n_fail++;
                $display("FAIL hold_left cyc=%0d got=%0d want=%0d", e.cyc, hold_left, e.hl);
            end
        end
    end

    initial begin
        int seg;
        logic r, p, m, h, a;

        // reset, manual on/off
        cycle(0, 1, 0, 0, 0, 3);
        cycle(1, 1, 1, 0, 0, 3);
        cycle(1, 1, 0, 0, 0, 3);
        // hood stop -> full hold to OFF
        cycle(1, 1, 0, 1, 0, 3);
        cycle(1, 1, 0, 0, 0, 35);
        // re-request during hold, then reload
        cycle(1, 1, 0, 1, 0, 2);
        cycle(1, 1, 0, 0, 0, 12);
        cycle(1, 1, 0, 1, 0, 2);
        cycle(1, 1, 0, 0, 0, 35);
        // simultaneous drop of manual and hood
        cycle(1, 1, 1, 1, 0, 2);
        cycle(1, 1, 0, 0, 0, 5);
        // blink, exit to ON, exit to OFF
        cycle(1, 1, 1, 0, 0, 2);
        cycle(1, 1, 1, 0, 1, 12);
        cycle(1, 1, 1, 0, 0, 3);
        cycle(1, 1, 0, 0, 1, 6);
        cycle(1, 1, 0, 0, 0, 3);
        // power override in hold, power drop with alarm rise
        cycle(1, 1, 0, 1, 0, 2);
        cycle(1, 1, 0, 0, 0, 12);
        cycle(1, 0, 0, 0, 0, 2);
        cycle(1, 1, 1, 0, 0, 2);
        cycle(1, 0, 1, 0, 1, 2);
        // reset mid-blink, blink restart
        cycle(1, 1, 0, 0, 1, 6);
        cycle(0, 1, 0, 0, 1, 2);
        cycle(1, 1, 0, 0, 1, 10);
        cycle(1, 1, 0, 0, 0, 2);

        // random segments of held inputs
        for (int s = 0; s < 200; s++) begin
            seg = $urandom_range(1, 45);
            r = ($urandom_range(0, 39) != 0);
            p = ($urandom_range(0, 7) != 0);
            m = ($urandom_range(0, 3) == 0);
            h = ($urandom_range(0, 1) == 0);
            a = ($urandom_range(0, 5) == 0);
            if (!r) seg = $urandom_range(1, 2);
            cycle(r, p, m, h, a, seg);
        end
        cycle(1, 1, 0, 0, 0, 3);

        @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain left=%0d want=0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
